// File: rtl/clasificador_pkg.sv
// Shared definitions for the ingress classifier: FSM encoding, lane constants and selector width.
package clasificador_pkg;

    localparam int unsigned SEL_BITS = 2;

    localparam logic [SEL_BITS-1:0] s0 = 2'b00;
    localparam logic [SEL_BITS-1:0] s1 = 2'b01;
    localparam logic [SEL_BITS-1:0] s2 = 2'b10;
    localparam logic [SEL_BITS-1:0] s3 = 2'b11;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StEnviar    = 2'b01,
        StBloqueado = 2'b10
    } estado_e;

endpackage

// File: rtl/fifo_sincrono.sv
// Synchronous DATA_BITS x FIFO_DEPTH buffer with registered full/empty flags and occupancy count.
module fifo_sincrono #(
    parameter int unsigned DATA_BITS  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_BITS   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] dato_in,
    output logic [DATA_BITS-1:0] head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_BITS-1:0]  count
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 full_q, empty_q;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_BITS'(FIFO_DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dato_in;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/clasificador_demux.sv
// Ingress classifier feeding the 4-way demux with per-lane head-of-line back-pressure.
// Optional issued-word counter on port cuenta when CONTADOR_ENVIOS_EN is defined.
module clasificador_demux
    import clasificador_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] dato_in,
    input  logic [3:0]           pausa,
    output logic                 enb,
    output logic [DATA_BITS-1:0] entrada,
    output logic [SEL_BITS-1:0]  selector,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 error
`ifdef CONTADOR_ENVIOS_EN
    ,
    output logic [7:0]           cuenta
`endif
);

    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] head;
    logic [CNT_BITS-1:0]  count;
    logic [SEL_BITS-1:0]  head_dest;
    logic                 pop_ok, push_ok;

    logic                 enb_q, enb_d;
    logic [DATA_BITS-1:0] entrada_q, entrada_d;
    logic [SEL_BITS-1:0]  selector_q, selector_d;
    logic                 error_q, error_d;
    estado_e              state_q, state_d;

    fifo_sincrono #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_BITS   (CNT_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_ok),
        .pop     (pop_ok),
        .dato_in (dato_in),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // A full FIFO still takes a word when the head leaves in the same cycle.
    always_comb begin
        head_dest = head[DATA_BITS-1 -: SEL_BITS];
        pop_ok    = !fifo_empty && !pausa[head_dest];
        push_ok   = push && (!fifo_full || pop_ok);
    end

    always_comb begin
        enb_d      = pop_ok;
        entrada_d  = pop_ok ? head : entrada_q;
        selector_d = pop_ok ? head_dest : selector_q;
        error_d    = error_q | (push & ~push_ok);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = pop_ok ? StEnviar : StBloqueado;
            end
            StEnviar: begin
                if (pop_ok) begin
                    if (count == CNT_BITS'(1) && !push_ok) state_d = StIdle;
                end else begin
                    state_d = fifo_empty ? StIdle : StBloqueado;
                end
            end
            StBloqueado: begin
                if (pop_ok) state_d = StEnviar;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enb_q      <= 1'b0;
            entrada_q  <= '0;
            selector_q <= '0;
            error_q    <= 1'b0;
            state_q    <= StIdle;
        end else begin
            enb_q      <= enb_d;
            entrada_q  <= entrada_d;
            selector_q <= selector_d;
            error_q    <= error_d;
            state_q    <= state_d;
        end
    end

`ifdef CONTADOR_ENVIOS_EN
    logic [7:0] cuenta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else if (pop_ok && cuenta_q != 8'hFF) begin
            cuenta_q <= cuenta_q + 8'd1;
        end
    end

    assign cuenta = cuenta_q;
`endif

    assign enb      = enb_q;
    assign entrada  = entrada_q;
    assign selector = selector_q;
    assign error    = error_q;

endmodule

// File: tb/tb_clasificador_demux.sv
// Scoreboard bench for clasificador_demux: stimulus queues expected {word, lane}, a monitor checks issues.
module tb_clasificador_demux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [3:0] dato_in = '0;
    logic [3:0] pausa = '0;
    logic       enb;
    logic [3:0] entrada;
    logic [1:0] selector;
    logic       fifo_full, fifo_empty, error;
`ifdef CONTADOR_ENVIOS_EN
    logic [7:0] cuenta;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] sb[$];

    clasificador_demux #(
        .DATA_BITS  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .dato_in    (dato_in),
        .pausa      (pausa),
        .enb        (enb),
        .entrada    (entrada),
        .selector   (selector),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .error      (error)
`ifdef CONTADOR_ENVIOS_EN
        ,
        .cuenta     (cuenta)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every enb pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (enb === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got entrada=%b selector=%b, expected no issue",
                         entrada, selector);
            end else begin
                logic [5:0] exp;
                exp = sb.pop_front();
                check("issue", {26'd0, entrada, selector}, {26'd0, exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic push_word(input logic [3:0] w, input logic [1:0] sel, input bit issues);
        push    = 1'b1;
        dato_in = w;
        if (issues) sb.push_back({w, sel});
        tick();
        push = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enb"}, 32'(enb), 32'd0);
        check({tag, "_entrada"}, 32'(entrada), 32'd0);
        check({tag, "_selector"}, 32'(selector), 32'd0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check({tag, "_full"}, 32'(fifo_full), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        do_reset();
        check_reset_outputs("reset");
        check("reset_state", 32'(dut.state_q), 32'd0);

        // Single word, latency of two edges, no bypass
        push_word(4'b0110, 2'b01, 1'b1);
        check("t1_no_bypass_enb", 32'(enb), 32'd0);
        check("t1_not_empty", 32'(fifo_empty), 32'd0);
        tick();
        check("t1_enb", 32'(enb), 32'd1);
        check("t1_entrada", 32'(entrada), 32'b0110);
        check("t1_selector", 32'(selector), 32'b01);
        tick();
        check("t1_enb_drop", 32'(enb), 32'd0);
        check("t1_hold_entrada", 32'(entrada), 32'b0110);

        // Four lanes back to back
        push_word(4'b0001, 2'b00, 1'b1);
        push_word(4'b0110, 2'b01, 1'b1);
        check("t2_enb_c1", 32'(enb), 32'd1);
        push_word(4'b1011, 2'b10, 1'b1);
        check("t2_enb_c2", 32'(enb), 32'd1);
        push_word(4'b1111, 2'b11, 1'b1);
        check("t2_enb_c3", 32'(enb), 32'd1);
        tick();
        check("t2_enb_c4", 32'(enb), 32'd1);
        check("t2_empty", 32'(fifo_empty), 32'd1);
        tick();
        check("t2_enb_end", 32'(enb), 32'd0);

        // Head-of-line blocking on lane 2
        pausa = 4'b0100;
        push_word(4'b1000, 2'b10, 1'b1);
        push_word(4'b0001, 2'b00, 1'b1);
        tick();
        tick();
        check("t3_blocked_enb", 32'(enb), 32'd0);
        check("t3_state_bloq", 32'(dut.state_q), 32'd2);
        check("t3_not_empty", 32'(fifo_empty), 32'd0);
        pausa = 4'b0000;
        tick();
        check("t3_first_sel", 32'(selector), 32'b10);
        tick();
        check("t3_second_sel", 32'(selector), 32'b00);
        tick();
        check("t3_state_idle", 32'(dut.state_q), 32'd0);
        check("t3_enb_end", 32'(enb), 32'd0);

        // Overflow while every lane is paused
        pausa = 4'b1111;
        push_word(4'b0001, 2'b00, 1'b0);
        push_word(4'b0110, 2'b01, 1'b0);
        push_word(4'b1011, 2'b10, 1'b0);
        push_word(4'b1100, 2'b11, 1'b0);
        check("t4_full", 32'(fifo_full), 32'd1);
        check("t4_no_error_yet", 32'(error), 32'd0);
        push_word(4'b1111, 2'b11, 1'b0);
        check("t4_error", 32'(error), 32'd1);
        check("t4_still_full", 32'(fifo_full), 32'd1);
        check("t4_count", 32'(dut.u_fifo.count), 32'd4);
        tick();
        check("t4_error_sticky", 32'(error), 32'd1);
        pausa = 4'b0000;
        do_reset();
        check_reset_outputs("t4_reset");

        // Push and pop together while full
        pausa = 4'b1111;
        push_word(4'b0010, 2'b00, 1'b1);
        push_word(4'b0101, 2'b01, 1'b1);
        push_word(4'b1001, 2'b10, 1'b1);
        push_word(4'b1110, 2'b11, 1'b1);
        pausa = 4'b0000;
        push_word(4'b0111, 2'b01, 1'b1);
        check("t5_enb", 32'(enb), 32'd1);
        check("t5_full", 32'(fifo_full), 32'd1);
        check("t5_count", 32'(dut.u_fifo.count), 32'd4);
        check("t5_error", 32'(error), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_drained", 32'(fifo_empty), 32'd1);

        // Reset mid-stream with three words still buffered
        pausa = 4'b1111;
        push_word(4'b0000, 2'b00, 1'b0);
        push_word(4'b0101, 2'b01, 1'b0);
        push_word(4'b1010, 2'b10, 1'b0);
        push_word(4'b1111, 2'b11, 1'b0);
        sb.push_back({4'b0000, 2'b00});
        pausa = 4'b0000;
        tick();
        check("t6_count_before", 32'(dut.u_fifo.count), 32'd3);
        do_reset();
        check_reset_outputs("t6_reset");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_quiet", 32'(enb), 32'd0);
        end
        push_word(4'b1101, 2'b11, 1'b1);
        tick();
        check("t6_enb", 32'(enb), 32'd1);
        check("t6_entrada", 32'(entrada), 32'b1101);
        check("t6_selector", 32'(selector), 32'b11);
        tick();

`ifdef CONTADOR_ENVIOS_EN
        do_reset();
        check("cnt_reset", 32'(cuenta), 32'd0);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] w;
            w = 4'(i);
            push_word(w, w[3:2], 1'b1);
            if (i == 0) begin
                tick();
                check("cnt_one", 32'(cuenta), 32'd1);
            end
        end
        for (int i = 0; i < 4; i++) tick();
        check("cnt_saturated", 32'(cuenta), 32'd255);
`endif

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
